crc_stream_engine: RTL and testbench

CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_byte_step.sv | 26 ++
 rtl/crc_stream_engine.sv | 86 ++++++++
 tb/tb_crc_stream_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// crc_pkg: shared types, CRC-32 defaults and the bit-reflection helper.
//   state_t  : engine FSM states (ACCUM collects message bytes, DONE holds a result)
//   reflect(): reverses the low w bits of a 32-bit value
package crc_pkg;
   typedef enum logic {ACCUM, DONE} state_t;
   localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
   function automatic logic [31:0] reflect(input logic [31:0] v, input int w);
      logic [31:0] r;
      int j;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         j = w - 1 - i;
         r[i] = (i < w) ? v[j[4:0]] : 1'b0;
      end
      return r;
   endfunction
endpackage

// File: rtl/crc_byte_step.sv
// crc_byte_step: combinational single-byte CRC update (MSB-first division).
//   crc_in  : CRC register before this byte
//   data    : message byte (bit-reversed first when REFIN=1)
//   en      : lane enable; when low the register passes through unchanged
//   crc_out : CRC register after this byte
module crc_byte_step #(
   parameter int          CRC_W = 32,
   parameter logic [31:0] POLY  = 32'h04C11DB7,
   parameter bit          REFIN = 1'b1
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic [7:0]       data,
   input  logic             en,
   output logic [CRC_W-1:0] crc_out
);
   localparam logic [CRC_W-1:0] P = POLY[CRC_W-1:0];
   logic [7:0]       b;
   logic [CRC_W-1:0] c;
   always_comb begin
      for (int i = 0; i < 8; i++) b[i] = REFIN ? data[7-i] : data[i];
      c = crc_in;
      // each message bit enters at the register MSB, highest bit first
      for (int i = 7; i >= 0; i--) c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b[i]) ? P : '0);
      crc_out = en ? c : crc_in;
   end
endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC over byte-lane-masked beats with a held result.
//   s_valid/s_ready/s_data/s_keep/s_last : input beat handshake, lane 0 processed first
//   s_abort                              : drops the message in progress (ACCUM only)
//   m_valid/m_ready/m_crc/m_len          : finalised CRC and saturating byte count
module crc_stream_engine
   import crc_pkg::*;
#(
   parameter int          DATA_W = 32,
   parameter int          CRC_W  = 32,
   parameter logic [31:0] POLY   = CRC32_POLY,
   parameter logic [31:0] INIT   = CRC32_INIT,
   parameter logic [31:0] XOROUT = CRC32_XOROUT,
   parameter bit          REFIN  = 1'b1,
   parameter bit          REFOUT = 1'b1,
   parameter int          LEN_W  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   input  logic [DATA_W/8-1:0] s_keep,
   input  logic                s_last,
   input  logic                s_abort,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [CRC_W-1:0]    m_crc,
   output logic [LEN_W-1:0]    m_len
);
   localparam int NB = DATA_W / 8;
   localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
   state_t             state_q, state_d;
   logic [CRC_W-1:0]   crc_q, crc_d, m_crc_q, m_crc_d, fin;
   logic [LEN_W-1:0]   len_q, len_d, m_len_q, m_len_d, len_new;
   logic               m_valid_q, m_valid_d, abort_act, acc, fin_beat;
   logic [LEN_W:0]     pop, sum;
   logic [CRC_W-1:0]   chain [0:NB];
   assign chain[0] = crc_q;
   for (genvar g = 0; g < NB; g++) begin : g_lane
      crc_byte_step #(.CRC_W(CRC_W), .POLY(POLY), .REFIN(REFIN)) u_step (
         .crc_in (chain[g]),
         .data   (s_data[8*g +: 8]),
         .en     (s_keep[g]),
         .crc_out(chain[g+1])
      );
   end
   assign s_ready = (state_q == ACCUM) | m_ready;
   assign m_valid = m_valid_q;
   assign m_crc   = m_crc_q;
   assign m_len   = m_len_q;
   always_comb begin
      pop = '0;
      for (int i = 0; i < NB; i++) pop = pop + (LEN_W+1)'(s_keep[i]);
      sum       = {1'b0, len_q} + pop;
      len_new   = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
      fin       = (REFOUT ? CRC_W'(reflect(32'(chain[NB]), CRC_W)) : chain[NB]) ^ XOROUT[CRC_W-1:0];
      abort_act = s_abort & (state_q == ACCUM);
      acc       = s_valid & s_ready & ~abort_act;
      fin_beat  = acc & s_last;
      // the working register is rewound at completion, so the next message
      // (possibly accepted in DONE) always starts from INIT and zero length
      crc_d     = (abort_act | fin_beat) ? INIT_C : acc ? chain[NB] : crc_q;
      len_d     = (abort_act | fin_beat) ? '0 : acc ? len_new : len_q;
      state_d   = fin_beat ? DONE : (state_q == DONE && m_ready) ? ACCUM : state_q;
      m_valid_d = fin_beat | (m_valid_q & ~m_ready);
      m_crc_d   = fin_beat ? fin : m_crc_q;
      m_len_d   = fin_beat ? len_new : m_len_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         crc_q     <= INIT_C;
         len_q     <= '0;
         m_valid_q <= 1'b0;
         m_crc_q   <= '0;
         m_len_q   <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         len_q     <= len_d;
         m_valid_q <= m_valid_d;
         m_crc_q   <= m_crc_d;
         m_len_q   <= m_len_d;
      end
   end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: randomized self-checking bench against a bytewise reflected CRC model.
module tb_crc_stream_engine;
   typedef logic [7:0] byte_q_t[$];
   localparam logic [31:0] P1 = 32'h04C11DB7;
   localparam logic [31:0] P2 = 32'h1EDC6F41;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        s_valid = 1'b0, s_last = 1'b0, s_abort = 1'b0, m_ready = 1'b0;
   logic [31:0] s_data = '0;
   logic [3:0]  s_keep = '0;
   logic        s_ready, m_valid, s_ready2, m_valid2;
   logic [31:0] m_crc, m_crc2;
   logic [15:0] m_len, m_len2;
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   crc_stream_engine dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .s_abort(s_abort), .m_valid(m_valid),
      .m_ready(m_ready), .m_crc(m_crc), .m_len(m_len)
   );
   crc_stream_engine #(.POLY(P2)) dut_c (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .s_abort(s_abort), .m_valid(m_valid2),
      .m_ready(m_ready), .m_crc(m_crc2), .m_len(m_len2)
   );
   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction
   // reflected (LSB-first) bytewise CRC: equivalent to REFIN=REFOUT=1, INIT=XOROUT=all ones
   function automatic logic [31:0] model_crc(input byte_q_t q, input logic [31:0] poly);
      logic [31:0] c, rp;
      c  = 32'hFFFFFFFF;
      rp = rev32(poly);
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
      end
      return ~c;
   endfunction
   function automatic logic [15:0] model_len(input byte_q_t q);
      return (q.size() > 65535) ? 16'hFFFF : 16'(q.size());
   endfunction
   task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic a = 1'b0);
      int n;
      s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; s_abort = a;
      n = 0;
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL beat_accept: s_ready=%b required 1 within 20 cycles", s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = $urandom; s_abort = 1'b0; s_keep = $urandom; s_data = $urandom;
   endtask
   task automatic send_bytes(input byte_q_t q);
      int n, i;
      logic [31:0] d;
      logic [3:0]  k;
      n = q.size();
      i = 0;
      if (n == 0) beat($urandom, 4'b0000, 1'b1);
      while (i < n) begin
         d = $urandom;
         k = '0;
         for (int j = 0; j < 4; j++) if (i + j < n) begin
            d[8*j +: 8] = q[i+j];
            k[j] = 1'b1;
         end
         i += 4;
         beat(d, k, i >= n);
      end
   endtask
   task automatic expect_result(input logic [31:0] e1, input logic [31:0] e2, input logic [15:0] el, input string name);
      checks++;
      if (m_valid !== 1'b1 || m_valid2 !== 1'b1) begin
         errors++; $display("FAIL %s_valid: m_valid=%b/%b required 1", name, m_valid, m_valid2);
      end
      checks++;
      if (m_crc !== e1) begin
         errors++; $display("FAIL %s_crc: got %h required %h", name, m_crc, e1);
      end
      checks++;
      if (m_crc2 !== e2) begin
         errors++; $display("FAIL %s_crc32c: got %h required %h", name, m_crc2, e2);
      end
      checks++;
      if (m_len !== el) begin
         errors++; $display("FAIL %s_len: got %0d required %0d", name, m_len, el);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++; $display("FAIL %s_consume: m_valid=%b required 0", name, m_valid);
      end
   endtask
   function automatic byte_q_t vec9();
      byte_q_t q;
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      return q;
   endfunction
   task automatic test_reset();
      checks++;
      if ({s_ready, m_valid, m_crc, m_len} !== {1'b1, 1'b0, 32'h0, 16'h0}) begin
         errors++;
         $display("FAIL reset_state: s_ready=%b m_valid=%b m_crc=%h m_len=%0d required 1 0 0 0", s_ready, m_valid, m_crc, m_len);
      end
   endtask
   task automatic test_check_vector();
      send_bytes(vec9());
      expect_result(32'hCBF43926, 32'hE3069283, 16'd9, "check_vector");
   endtask
   task automatic test_single_and_empty();
      byte_q_t q;
      q = '{8'h00};
      send_bytes(q);
      expect_result(32'hD202EF8D, model_crc(q, P2), 16'd1, "single_zero");
      q = {};
      send_bytes(q);
      expect_result(32'h00000000, 32'h00000000, 16'd0, "empty");
   endtask
   task automatic test_random();
      byte_q_t     q;
      int          nb;
      logic [31:0] d;
      logic [3:0]  k;
      for (int m = 0; m < 40; m++) begin
         q  = {};
         nb = $urandom_range(1, 5);
         for (int b = 0; b < nb; b++) begin
            d = $urandom;
            k = $urandom;
            for (int j = 0; j < 4; j++) if (k[j]) q.push_back(d[8*j +: 8]);
            beat(d, k, b == nb - 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         expect_result(model_crc(q, P1), model_crc(q, P2), model_len(q), "random");
      end
   endtask
   task automatic test_backpressure();
      send_bytes(vec9());
      s_valid = 1'b1; s_data = 32'h34333231; s_keep = 4'hF; s_last = 1'b0; m_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({m_valid, s_ready, m_crc, m_len} !== {1'b1, 1'b0, 32'hCBF43926, 16'd9}) begin
            errors++;
            $display("FAIL hold_stable: m_valid=%b s_ready=%b m_crc=%h m_len=%0d required 1 0 cbf43926 9", m_valid, s_ready, m_crc, m_len);
         end
      end
      m_ready = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL release_ready: s_ready=%b required 1", s_ready);
      end
      @(negedge clk);
      m_ready = 1'b0; s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++; $display("FAIL release_consume: m_valid=%b required 0", m_valid);
      end
      beat(32'h38373635, 4'hF, 1'b0);
      beat(32'h00000039, 4'h1, 1'b1);
      expect_result(32'hCBF43926, 32'hE3069283, 16'd9, "after_hold");
   endtask
   task automatic test_abort();
      beat(32'h34333231, 4'hF, 1'b0);
      beat(32'h38373635, 4'hF, 1'b0);
      beat($urandom, $urandom, 1'b1, 1'b1);
      send_bytes(vec9());
      expect_result(32'hCBF43926, 32'hE3069283, 16'd9, "abort_resend");
      send_bytes(vec9());
      s_abort = 1'b1;
      repeat (2) @(negedge clk);
      s_abort = 1'b0;
      expect_result(32'hCBF43926, 32'hE3069283, 16'd9, "abort_in_done");
   endtask
   task automatic test_back_to_back();
      byte_q_t     q;
      logic [31:0] d;
      send_bytes(vec9());
      d = $urandom;
      q = '{d[15:8]};
      checks++;
      if (m_crc !== 32'hCBF43926) begin
         errors++; $display("FAIL b2b_first: got %h required cbf43926", m_crc);
      end
      m_ready = 1'b1; s_valid = 1'b1; s_data = d; s_keep = 4'b0010; s_last = 1'b1;
      @(negedge clk);
      m_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      expect_result(model_crc(q, P1), model_crc(q, P2), 16'd1, "b2b_second");
   endtask
   task automatic test_reset_mid();
      send_bytes(vec9());
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({s_ready, m_valid, m_crc, m_len} !== {1'b1, 1'b0, 32'h0, 16'h0}) begin
         errors++;
         $display("FAIL async_reset: s_ready=%b m_valid=%b m_crc=%h m_len=%0d required 1 0 0 0", s_ready, m_valid, m_crc, m_len);
      end
      @(negedge clk);
      rst_n = 1'b1;
      beat(32'h34333231, 4'hF, 1'b0);
      beat(32'h38373635, 4'hF, 1'b0);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_bytes(vec9());
      expect_result(32'hCBF43926, 32'hE3069283, 16'd9, "after_reset");
   endtask
   task automatic test_saturation();
      byte_q_t     q;
      logic [31:0] d;
      for (int b = 0; b < 16400; b++) begin
         d = $urandom;
         for (int j = 0; j < 4; j++) q.push_back(d[8*j +: 8]);
         beat(d, 4'hF, b == 16399);
      end
      expect_result(model_crc(q, P1), model_crc(q, P2), 16'hFFFF, "saturation");
   endtask
   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_check_vector();
      test_single_and_empty();
      test_random();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
